// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types, default parameters and helpers for the
// run-time clock divider controller.
//   state_t        : controller states (IDLE, RUN, STOPPING)
//   DEF_SCALE      : default half-period loaded at reset
//   DEF_MAX_SCALE  : default largest legal half-period
//   scale_is_legal : 1 when a scale lies in 1..max_s
package clk_div_pkg;

  localparam int unsigned DEF_SCALE     = 2;
  localparam int unsigned DEF_MAX_SCALE = 256;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  function automatic logic scale_is_legal(input logic [31:0] s,
                                          input logic [31:0] max_s);
    return (s != 32'd0) && (s <= max_s);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: half-period counter and clock_out toggle.
//   i_clk      : clock
//   i_reset    : synchronous active-high reset
//   i_run      : divide while high; counter and output held at 0 when low
//   i_clear    : force counter and output to 0 (clean stop from low phase)
//   i_scale    : half-period length in cycles (1..2**SW-1)
//   o_boundary : high in the cycle whose edge ends the current half-period
//   o_clk      : divided clock
//   o_tick     : one-cycle pulse in the first cycle of each new o_clk level
module clk_div_core #(
  parameter int unsigned SW = 9
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_run,
  input  logic          i_clear,
  input  logic [SW-1:0] i_scale,
  output logic          o_boundary,
  output logic          o_clk,
  output logic          o_tick
);

  logic [SW-1:0] r_count;
  logic          r_clk;
  logic          r_tick;

  assign o_boundary = i_run && (r_count == (i_scale - SW'(1)));
  assign o_clk      = r_clk;
  assign o_tick     = r_tick;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run || i_clear) begin
      r_count <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else if (o_boundary) begin
      r_count <= '0;
      r_clk   <= ~r_clk;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + SW'(1);
      r_tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: start/stop sequencing and valid/ready scale configuration
// for the system clock divider. Scale changes and stops land only on
// half-period boundaries so clock_out never produces a runt pulse.
//   clock_in     : clock
//   reset        : synchronous active-high reset
//   start        : begin/resume division (level)
//   stop         : request a clean stop with clock_out low (level)
//   cfg_valid    : new scale offered
//   cfg_scale    : offered half-period in cycles
//   cfg_ready    : controller can accept a scale (low while one is pending)
//   cfg_err      : one-cycle pulse when an illegal scale was accepted
//   clock_out    : divided clock
//   tick         : pulse in the first cycle of every new clock_out level
//   running      : state is not IDLE
//   active_scale : scale currently in force
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter  int unsigned MAX_SCALE     = DEF_MAX_SCALE,
  parameter  int unsigned DEFAULT_SCALE = DEF_SCALE,
  localparam int unsigned SW            = $clog2(MAX_SCALE + 1)
) (
  input  logic          clock_in,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_valid,
  input  logic [SW-1:0] cfg_scale,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          clock_out,
  output logic          tick,
  output logic          running,
  output logic [SW-1:0] active_scale
);

  state_t        r_state;
  state_t        w_next;
  logic          w_clear;
  logic          w_boundary;
  logic          w_accept;
  logic          w_legal;
  logic          r_pend;
  logic [SW-1:0] r_pend_scale;
  logic [SW-1:0] r_active;
  logic          r_err;

  clk_div_core #(.SW(SW)) u_core (
    .i_clk      (clock_in),
    .i_reset    (reset),
    .i_run      (r_state != IDLE),
    .i_clear    (w_clear),
    .i_scale    (r_active),
    .o_boundary (w_boundary),
    .o_clk      (clock_out),
    .o_tick     (tick)
  );

  assign running      = (r_state != IDLE);
  assign cfg_ready    = ~r_pend;
  assign cfg_err      = r_err;
  assign active_scale = r_active;
  assign w_accept     = cfg_valid && !r_pend;
  assign w_legal      = scale_is_legal(32'(cfg_scale), MAX_SCALE);

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !stop) w_next = RUN;
      end
      RUN: begin
        if (stop) begin
          if (!clock_out) begin
            w_next  = IDLE;
            w_clear = 1'b1;
          end else if (w_boundary) begin
            // high phase ends on this very edge: the fall is already clean
            w_next = IDLE;
          end else begin
            w_next = STOPPING;
          end
        end
      end
      STOPPING: begin
        if (start && !stop) w_next = RUN;
        else if (w_boundary) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pend       <= 1'b0;
      r_pend_scale <= '0;
      r_active     <= SW'(DEFAULT_SCALE);
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && !w_legal;
      if (r_pend) begin
        // pending scale lands on a boundary or whenever the divider is idle
        if (w_boundary || (w_next == IDLE) || (r_state == IDLE)) begin
          r_active <= r_pend_scale;
          r_pend   <= 1'b0;
        end
      end else if (w_accept && w_legal) begin
        if (r_state == IDLE) begin
          r_active <= cfg_scale;
        end else begin
          r_pend       <= 1'b1;
          r_pend_scale <= cfg_scale;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic       clock_in = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       cfg_valid;
  logic [8:0] cfg_scale;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clock_out;
  logic       tick;
  logic       running;
  logic [8:0] active_scale;

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_ctrl #(.MAX_SCALE(256), .DEFAULT_SCALE(2)) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .cfg_valid    (cfg_valid),
    .cfg_scale    (cfg_scale),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .clock_out    (clock_out),
    .tick         (tick),
    .running      (running),
    .active_scale (active_scale)
  );

  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_scale = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; stop = 1'b0; cfg_valid = 1'b0; cfg_scale = '0;
    step(); step();
    n_checks++; if (clock_out !== 1'b0) begin n_fail++; $display("FAIL reset clock_out: got %b expected 0", clock_out); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset tick: got %b expected 0", tick); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset running: got %b expected 0", running); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset cfg_ready: got %b expected 1", cfg_ready); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset cfg_err: got %b expected 0", cfg_err); end
    n_checks++; if (active_scale !== 9'd2) begin n_fail++; $display("FAIL reset active_scale: got %0d expected 2", active_scale); end
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_default_run();
    apply_reset();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (clock_out !== (((i / 2) % 2) == 1)) begin n_fail++; $display("FAIL default clock_out[%0d]: got %b expected %b", i, clock_out, ((i / 2) % 2) == 1); end
      n_checks++; if (tick !== ((i >= 2) && (i % 2 == 0))) begin n_fail++; $display("FAIL default tick[%0d]: got %b expected %b", i, tick, (i >= 2) && (i % 2 == 0)); end
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL default running[%0d]: got %b expected 1", i, running); end
      step();
    end
  endtask

  task automatic test_idle_cfg();
    apply_reset();
    cfg_valid = 1'b1; cfg_scale = 9'd5; step(); cfg_valid = 1'b0;
    n_checks++; if (active_scale !== 9'd5) begin n_fail++; $display("FAIL idle_cfg active_scale: got %0d expected 5", active_scale); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cfg cfg_ready: got %b expected 1", cfg_ready); end
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 22; i++) begin
      n_checks++; if (clock_out !== (((i / 5) % 2) == 1)) begin n_fail++; $display("FAIL idle_cfg clock_out[%0d]: got %b expected %b", i, clock_out, ((i / 5) % 2) == 1); end
      n_checks++; if (tick !== ((i > 0) && (i % 5 == 0))) begin n_fail++; $display("FAIL idle_cfg tick[%0d]: got %b expected %b", i, tick, (i > 0) && (i % 5 == 0)); end
      step();
    end
  endtask

  task automatic test_scale_one();
    apply_reset();
    cfg_valid = 1'b1; cfg_scale = 9'd1; step(); cfg_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL scale1 tick[%0d]: got %b expected 1", i, tick); end
      end
      n_checks++; if (clock_out !== ((i % 2) == 1)) begin n_fail++; $display("FAIL scale1 clock_out[%0d]: got %b expected %b", i, clock_out, (i % 2) == 1); end
      step();
    end
  endtask

  task automatic test_cfg_in_run();
    logic exp_c;
    apply_reset();
    cfg_valid = 1'b1; cfg_scale = 9'd3; step(); cfg_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 28; i++) begin
      if (i < 3) exp_c = 1'b0;
      else if (i < 6) exp_c = 1'b1;
      else exp_c = (((i - 6) / 7) % 2) == 1;
      n_checks++; if (clock_out !== exp_c) begin n_fail++; $display("FAIL cfg_run clock_out[%0d]: got %b expected %b", i, clock_out, exp_c); end
      n_checks++; if (cfg_ready !== (i != 5)) begin n_fail++; $display("FAIL cfg_run cfg_ready[%0d]: got %b expected %b", i, cfg_ready, i != 5); end
      n_checks++; if (active_scale !== ((i < 6) ? 9'd3 : 9'd7)) begin n_fail++; $display("FAIL cfg_run active_scale[%0d]: got %0d expected %0d", i, active_scale, (i < 6) ? 3 : 7); end
      cfg_valid = (i == 4); cfg_scale = 9'd7;
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_stop_high();
    apply_reset();
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    n_checks++; if (clock_out !== 1'b1) begin n_fail++; $display("FAIL stop_high pre clock_out: got %b expected 1", clock_out); end
    stop = 1'b1; step();
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL stop_high stopping running: got %b expected 1", running); end
    n_checks++; if (clock_out !== 1'b1) begin n_fail++; $display("FAIL stop_high stopping clock_out: got %b expected 1", clock_out); end
    step();
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL stop_high idle running: got %b expected 0", running); end
    n_checks++; if (clock_out !== 1'b0) begin n_fail++; $display("FAIL stop_high idle clock_out: got %b expected 0", clock_out); end
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL stop_high fall tick: got %b expected 1", tick); end
    stop = 1'b0; step();
    n_checks++; if (tick !== 1'b0 || clock_out !== 1'b0) begin n_fail++; $display("FAIL stop_high after tick/clock_out: got %b/%b expected 0/0", tick, clock_out); end
  endtask

  task automatic test_stop_low();
    apply_reset();
    cfg_valid = 1'b1; cfg_scale = 9'd5; step(); cfg_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step();
    stop = 1'b1; step(); stop = 1'b0;
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL stop_low running: got %b expected 0", running); end
    n_checks++; if (clock_out !== 1'b0) begin n_fail++; $display("FAIL stop_low clock_out: got %b expected 0", clock_out); end
    step(); step(); step(); step();
    n_checks++; if (clock_out !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL stop_low hold clock_out/running: got %b/%b expected 0/0", clock_out, running); end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL start_stop_idle running: got %b expected 0", running); end
  endtask

  task automatic test_stop_resume();
    apply_reset();
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    stop = 1'b1; step(); stop = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 4; i < 12; i++) begin
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume running[%0d]: got %b expected 1", i, running); end
      n_checks++; if (clock_out !== (((i / 2) % 2) == 1)) begin n_fail++; $display("FAIL resume clock_out[%0d]: got %b expected %b", i, clock_out, ((i / 2) % 2) == 1); end
      n_checks++; if (tick !== (i % 2 == 0)) begin n_fail++; $display("FAIL resume tick[%0d]: got %b expected %b", i, tick, i % 2 == 0); end
      step();
    end
  endtask

  task automatic test_cfg_err();
    apply_reset();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (cfg_err !== ((i == 2) || (i == 3))) begin n_fail++; $display("FAIL cfg_err pulse[%0d]: got %b expected %b", i, cfg_err, (i == 2) || (i == 3)); end
      n_checks++; if (active_scale !== 9'd2) begin n_fail++; $display("FAIL cfg_err active_scale[%0d]: got %0d expected 2", i, active_scale); end
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_err cfg_ready[%0d]: got %b expected 1", i, cfg_ready); end
      n_checks++; if (clock_out !== (((i / 2) % 2) == 1)) begin n_fail++; $display("FAIL cfg_err clock_out[%0d]: got %b expected %b", i, clock_out, ((i / 2) % 2) == 1); end
      cfg_valid = (i == 1) || (i == 2);
      cfg_scale = (i == 1) ? 9'd0 : 9'd257;
      step();
    end
    cfg_valid = 1'b0;
    apply_reset();
    cfg_valid = 1'b1; cfg_scale = 9'd256; step(); cfg_valid = 1'b0;
    n_checks++; if (active_scale !== 9'd256) begin n_fail++; $display("FAIL cfg_max active_scale: got %0d expected 256", active_scale); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_max cfg_err: got %b expected 0", cfg_err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    cfg_valid = 1'b1; cfg_scale = 9'd9; step(); cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0 || clock_out !== 1'b1) begin n_fail++; $display("FAIL reset_mid pre cfg_ready/clock_out: got %b/%b expected 0/1", cfg_ready, clock_out); end
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (clock_out !== 1'b0) begin n_fail++; $display("FAIL reset_mid clock_out: got %b expected 0", clock_out); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_mid tick: got %b expected 0", tick); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_mid running: got %b expected 0", running); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid cfg_ready: got %b expected 1", cfg_ready); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_mid cfg_err: got %b expected 0", cfg_err); end
    n_checks++; if (active_scale !== 9'd2) begin n_fail++; $display("FAIL reset_mid active_scale: got %0d expected 2", active_scale); end
    step(); step(); step();
    n_checks++; if (active_scale !== 9'd2) begin n_fail++; $display("FAIL reset_mid pending dropped: got %0d expected 2", active_scale); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_default_run();
    test_idle_cfg();
    test_scale_one();
    test_cfg_in_run();
    test_stop_high();
    test_stop_low();
    test_stop_resume();
    test_cfg_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
